spi_frame_responder: RTL and testbench

//  SPI mode-0 slave frame engine: the responder end of the 16-bit {rw,addr[6:0],data[7:0]} protocol driven by the bench SPI master.

---
 rtl/spi_frame_responder_pkg.sv | 22 ++
 rtl/spi_frame_responder_if.sv | 23 ++
 rtl/spi_frame_responder_sync_edge.sv | 29 ++
 rtl/spi_frame_responder.sv | 205 ++++++++++++++++++++
 tb/tb_spi_frame_responder.sv | 195 +++++++++++++++++++
 5 files changed

// File: rtl/spi_frame_responder_pkg.sv
// Shared types and frame geometry for the SPI frame responder.
// Frame layout is {rw, addr, data}, transmitted MSB first.
package spi_frame_pkg;

    localparam int ADDR_WIDTH_DEF = 7;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int FRAME_WIDTH    = 1 + ADDR_WIDTH_DEF + DATA_WIDTH_DEF;
    localparam logic RW_READ      = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_RD_FETCH,
        ST_DATA,
        ST_DONE
    } state_t;

    function automatic int frame_width(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_frame_responder_if.sv
// Single-cycle register bus between the frame responder (master) and a register file (slave).
// rd_data is sampled by the master exactly one clock after rd_en.
interface spi_frame_responder_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 8
);
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_en;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [DATA_WIDTH-1:0] rd_data;

    modport master (
        output wr_en, wr_addr, wr_data, rd_en, rd_addr,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, rd_en, rd_addr,
        output rd_data
    );
endinterface

// File: rtl/spi_frame_responder_sync_edge.sv
// Synchroniser chain for one asynchronous pad plus rise/fall pulses taken from the last two stages.
// sync_q[0] is the newest sample, sync_q[SYNC_STAGES-1] the oldest.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2,
    parameter bit RESET_VAL   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= {SYNC_STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  =  sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign fall_o  = ~sync_q[SYNC_STAGES-2] &  sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_frame_responder.sv
// SPI mode-0 slave frame engine: decodes {rw,addr,data} frames from oversampled pads and
// issues single-cycle register-bus writes/reads, returning read data on sdo_o MSB first.
module spi_frame_responder
    import spi_frame_pkg::*;
#(
    parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
    parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic sck_i,
    input  logic sdi_i,
    input  logic cs_ni,
    output logic sdo_o,
    output logic sdo_oe,
    output logic frame_err,
    spi_frame_responder_if.master bus
);

    localparam int FW       = frame_width(ADDR_WIDTH, DATA_WIDTH);
    localparam int CMD_BITS = 1 + ADDR_WIDTH;
    localparam int CNT_W    = $clog2(FW);
    localparam int N_PADS   = 3;
    localparam int IDX_CS   = 0;
    localparam int IDX_SCK  = 1;
    localparam int IDX_SDI  = 2;
    // cs idles high; reset its synchroniser there so reset never looks like a frame start
    localparam logic [N_PADS-1:0] PAD_IDLE = 3'b001;

    logic [N_PADS-1:0] pad_w, lvl_w, rise_w, fall_w;
    assign pad_w = {sdi_i, sck_i, cs_ni};

    generate
        for (genvar gi = 0; gi < N_PADS; gi++) begin : g_sync
            spi_sync_edge #(
                .SYNC_STAGES (SYNC_STAGES),
                .RESET_VAL   (PAD_IDLE[gi])
            ) u_sync (
                .clk     (clk),
                .rst_n   (rst_n),
                .d_i     (pad_w[gi]),
                .level_o (lvl_w[gi]),
                .rise_o  (rise_w[gi]),
                .fall_o  (fall_w[gi])
            );
        end
    endgenerate

    logic cs_rise, cs_fall, sck_rise, sck_fall, sdi_bit, frame_active;
    assign cs_rise  = rise_w[IDX_CS];
    assign cs_fall  = fall_w[IDX_CS];
    assign sck_rise = rise_w[IDX_SCK];
    assign sck_fall = fall_w[IDX_SCK];
    assign sdi_bit  = lvl_w[IDX_SDI];

    logic unused_sync;
    assign unused_sync = &{1'b0, lvl_w[IDX_SCK], rise_w[IDX_SDI], fall_w[IDX_SDI]};

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [FW-2:0]         rx_q, rx_d;
    logic [FW-1:0]         frame_next;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic                  sdo_q, sdo_d;
    logic                  fetch_q, fetch_d;
    logic                  wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d, rd_addr_q, rd_addr_d;
    logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic                  frame_err_q, frame_err_d;

    assign frame_next   = {rx_q, sdi_bit};
    assign frame_active = (state_q == ST_CMD) || (state_q == ST_RD_FETCH) || (state_q == ST_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cs_fall) state_d = ST_CMD;
            ST_CMD: begin
                if (cs_rise) begin
                    state_d = ST_IDLE;
                end else if (sck_rise && cnt_q == CNT_W'(CMD_BITS - 1)) begin
                    state_d = (rx_q[CMD_BITS-2] == RW_READ) ? ST_RD_FETCH : ST_DATA;
                end
            end
            ST_RD_FETCH: begin
                if (cs_rise)      state_d = ST_IDLE;
                else if (fetch_q) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (cs_rise)                                    state_d = ST_IDLE;
                else if (sck_rise && cnt_q == CNT_W'(FW - 1))   state_d = ST_DONE;
            end
            ST_DONE: if (cs_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: shift registers, counter and bus strobes
    always_comb begin
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        sdo_d       = sdo_q;
        fetch_d     = 1'b0;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        rd_addr_d   = rd_addr_q;
        frame_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                sdo_d = 1'b0;
                if (cs_fall) begin
                    cnt_d = '0;
                    rx_d  = '0;
                    tx_d  = '0;
                end
            end
            ST_CMD: begin
                if (sck_rise) begin
                    rx_d  = frame_next[FW-2:0];
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(CMD_BITS - 1)) rd_addr_d = frame_next[ADDR_WIDTH-1:0];
                end
            end
            ST_RD_FETCH: begin
                fetch_d = ~fetch_q;
                if (fetch_q) tx_d = bus.rd_data;
            end
            ST_DATA: begin
                if (sck_fall) begin
                    sdo_d = tx_q[DATA_WIDTH-1];
                    tx_d  = {tx_q[DATA_WIDTH-2:0], 1'b0};
                end
                if (sck_rise) begin
                    rx_d = frame_next[FW-2:0];
                    // Last bit: hold the counter so it never wraps
                    if (cnt_q == CNT_W'(FW - 1)) begin
                        if (frame_next[FW-1] != RW_READ) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = frame_next[FW-2 -: ADDR_WIDTH];
                            wr_data_d = frame_next[DATA_WIDTH-1:0];
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: ;
        endcase
        if (cs_rise) begin
            sdo_d   = 1'b0;
            fetch_d = 1'b0;
            wr_en_d = 1'b0;
            if (frame_active) frame_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            sdo_q       <= 1'b0;
            fetch_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            rd_addr_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            sdo_q       <= sdo_d;
            fetch_q     <= fetch_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
            rd_addr_q   <= rd_addr_d;
            frame_err_q <= frame_err_d;
        end
    end

    always_comb begin
        bus.rd_en   = (state_q == ST_RD_FETCH) && !fetch_q;
        bus.rd_addr = rd_addr_q;
        bus.wr_en   = wr_en_q;
        bus.wr_addr = wr_addr_q;
        bus.wr_data = wr_data_q;
        sdo_o       = sdo_q;
        sdo_oe      = ~lvl_w[IDX_CS];
        frame_err   = frame_err_q;
    end

endmodule

// File: tb/tb_spi_frame_responder.sv
// Directed bench: bit-banged SPI master, register-file model on the bus, and a queue of
// expected bus strobes popped as the responder issues them.
module tb_spi_frame_responder;
    import spi_frame_pkg::*;

    typedef struct packed {
        logic       is_read;
        logic [6:0] addr;
        logic [7:0] data;
    } exp_t;

    logic clk = 1'b0, rst_n = 1'b0, sck = 1'b0, sdi = 1'b0, cs_n = 1'b1;
    logic sdo, sdo_oe, frame_err;

    spi_frame_responder_if #(.ADDR_WIDTH(7), .DATA_WIDTH(8)) bus ();

    spi_frame_responder #(.ADDR_WIDTH(7), .DATA_WIDTH(8), .SYNC_STAGES(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sck_i     (sck),
        .sdi_i     (sdi),
        .cs_ni     (cs_n),
        .sdo_o     (sdo),
        .sdo_oe    (sdo_oe),
        .frame_err (frame_err),
        .bus       (bus)
    );

    always #50 clk = ~clk;

    logic [7:0] regfile [128];
    logic [7:0] exp_mem [128];
    exp_t exp_q[$];
    int n_checks = 0, n_pass = 0, n_fail = 0;
    int wr_cnt = 0, rd_cnt = 0, err_cnt = 0;

    // Register file: rd_data is valid only in the cycle after rd_en
    always @(posedge clk) begin
        if (bus.wr_en) regfile[bus.wr_addr] <= bus.wr_data;
        bus.rd_data <= bus.rd_en ? regfile[bus.rd_addr] : 8'h00;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (rst_n) begin
            if (bus.wr_en || bus.rd_en || frame_err)
                chk("strobe_onehot", 32'($onehot0({bus.wr_en, bus.rd_en, frame_err})), 32'd1);
            if (frame_err) err_cnt++;
            if (bus.wr_en) begin
                wr_cnt++;
                chk("wr_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("bus write addr=0x%02h data=0x%02h", bus.wr_addr, bus.wr_data);
                    chk("wr_kind", 32'(e.is_read), 32'd0);
                    chk("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
                    chk("wr_data", 32'(bus.wr_data), 32'(e.data));
                end
            end
            if (bus.rd_en) begin
                rd_cnt++;
                chk("rd_pending", 32'(exp_q.size() > 0), 32'd1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    $display("bus read  addr=0x%02h", bus.rd_addr);
                    chk("rd_kind", 32'(e.is_read), 32'd1);
                    chk("rd_addr", 32'(bus.rd_addr), 32'(e.addr));
                end
            end
        end
    end

    task automatic spi_frame(input logic [FRAME_WIDTH-1:0] tx, input int nbits, input bit release_cs,
                             output logic [FRAME_WIDTH-1:0] rx, output logic oe_seen);
        rx = '0;
        oe_seen = 1'b0;
        cs_n = 1'b0;
        #500;
        for (int i = 0; i < nbits; i++) begin
            sdi = tx[FRAME_WIDTH-1-i];
            #500 sck = 1'b1;
            rx = {rx[FRAME_WIDTH-2:0], sdo};
            if (i == 0) oe_seen = sdo_oe;
            #500 sck = 1'b0;
        end
        sdi = 1'b0;
        if (release_cs) begin
            #500 cs_n = 1'b1;
            #1000;
        end
    endtask

    task automatic do_write(input logic [6:0] a, input logic [7:0] d);
        logic [15:0] rx;
        logic oe;
        int s;
        exp_q.push_back('{1'b0, a, d});
        exp_mem[a] = d;
        s = wr_cnt + rd_cnt;
        spi_frame({1'b0, a, d}, 16, 1'b1, rx, oe);
        chk("w_one_strobe", 32'(wr_cnt + rd_cnt - s), 32'd1);
        chk("w_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_read(input logic [6:0] a, output logic oe);
        logic [15:0] rx;
        int s;
        exp_q.push_back('{1'b1, a, 8'h00});
        s = wr_cnt + rd_cnt;
        spi_frame({1'b1, a, 8'h00}, 16, 1'b1, rx, oe);
        $display("spi read  addr=0x%02h got=0x%02h", a, rx[7:0]);
        chk("r_one_strobe", 32'(wr_cnt + rd_cnt - s), 32'd1);
        chk("r_drained", 32'(exp_q.size()), 32'd0);
        chk("r_cmd_sdo_low", 32'(rx[15:8]), 32'd0);
        chk("r_value", 32'(rx[7:0]), 32'(exp_mem[a]));
    endtask

    initial begin
        logic [15:0] rx;
        logic oe;
        int s_err, s_wr;
        logic [6:0] ra;
        logic [7:0] rd;

        for (int i = 0; i < 128; i++) begin
            regfile[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        regfile[14] = 8'hFF;
        exp_mem[14] = 8'hFF;

        @(negedge clk);
        chk("rst_outputs", 32'({bus.wr_en, bus.rd_en, frame_err, sdo, sdo_oe}), 32'd0);
        chk("rst_regs", 32'({bus.wr_addr, bus.wr_data, bus.rd_addr}), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        do_write(7'h05, 8'hA5);
        do_read(7'h05, oe);
        do_read(7'h0E, oe);
        chk("oe_in_frame", 32'(oe), 32'd1);
        chk("oe_after_cs", 32'(sdo_oe), 32'd0);

        // Write aborted after 10 sck cycles
        s_err = err_cnt;
        s_wr  = wr_cnt;
        spi_frame(16'h033C, 10, 1'b1, rx, oe);
        $display("aborted frame after 10 bits");
        chk("abort_frame_err", 32'(err_cnt - s_err), 32'd1);
        chk("abort_no_wr", 32'(wr_cnt - s_wr), 32'd0);
        do_write(7'h03, 8'h3C);
        do_read(7'h03, oe);

        // Reset in the data phase of a read
        exp_q.push_back('{1'b1, 7'h0E, 8'h00});
        s_err = err_cnt;
        spi_frame(16'h8E00, 11, 1'b0, rx, oe);
        rst_n = 1'b0;
        #1;
        $display("reset asserted mid-read");
        chk("midrst_outputs", 32'({bus.wr_en, bus.rd_en, frame_err, sdo, sdo_oe}), 32'd0);
        chk("midrst_regs", 32'({bus.wr_addr, bus.wr_data, bus.rd_addr}), 32'd0);
        chk("midrst_drained", 32'(exp_q.size()), 32'd0);
        cs_n = 1'b1;
        sck  = 1'b0;
        #299 rst_n = 1'b1;
        #1000;
        chk("midrst_no_err", 32'(err_cnt - s_err), 32'd0);
        do_write(7'h00, 8'h11);
        do_read(7'h00, oe);

        // Random write/read pairs
        for (int i = 0; i < 8; i++) begin
            ra = 7'($urandom_range(0, 15));
            rd = 8'($urandom_range(0, 255));
            do_write(ra, rd);
            do_read(ra, oe);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
